// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction-fetch unit.
// Holds the default sizing of the miss-request controller and the tag and
// line types exchanged between the cache and the instruction memory.
package ifu_pkg;

    localparam int IFU_MAX_OUTSTANDING = 4;
    localparam int IFU_TAG_WIDTH       = 6;
    localparam int IFU_LINE_WIDTH      = 32;
    localparam int IFU_OFFSET_WIDTH    = 5;
    localparam int IFU_ADDR_WIDTH      = 32;

    typedef logic [IFU_TAG_WIDTH-1:0]  t_ifu_tag;
    typedef logic [IFU_LINE_WIDTH-1:0] t_ifu_line;

endpackage

// File: rtl/ifu_mem_req_ctrl_if.sv
// ifu_mem_req_ctrl_if: bundle of the cache-side and memory-side signals of the
// miss-request controller.
//   master modport - the controller (drives ready, memory request, fill, error)
//   slave  modport - the environment (drives miss requests, memory ready/response)
interface ifu_mem_req_ctrl_if
    import ifu_pkg::*;
#(
    parameter int TAG_WIDTH  = IFU_TAG_WIDTH,
    parameter int LINE_WIDTH = IFU_LINE_WIDTH,
    parameter int ADDR_WIDTH = IFU_ADDR_WIDTH
) ();

    logic [TAG_WIDTH-1:0]  cache_reqTagIn;
    logic                  cache_reqTagValidIn;
    logic                  cache_reqReadyOut;
    logic [ADDR_WIDTH-1:0] mem_reqAddrOut;
    logic                  mem_reqValidOut;
    logic                  mem_reqReadyIn;
    logic [LINE_WIDTH-1:0] mem_rspInsLineIn;
    logic                  mem_rspValidIn;
    logic [TAG_WIDTH-1:0]  cache_rspTagOut;
    logic [LINE_WIDTH-1:0] cache_rspInsLineOut;
    logic                  cache_rspInsLineValidOut;
    logic                  err_unexpRspOut;

    modport master (
        input  cache_reqTagIn, cache_reqTagValidIn,
        output cache_reqReadyOut,
        output mem_reqAddrOut, mem_reqValidOut,
        input  mem_reqReadyIn, mem_rspInsLineIn, mem_rspValidIn,
        output cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
        output err_unexpRspOut
    );

    modport slave (
        output cache_reqTagIn, cache_reqTagValidIn,
        input  cache_reqReadyOut,
        input  mem_reqAddrOut, mem_reqValidOut,
        output mem_reqReadyIn, mem_rspInsLineIn, mem_rspValidIn,
        input  cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
        input  err_unexpRspOut
    );

endinterface

// File: rtl/ifu_pend_tag_q.sv
// ifu_pend_tag_q: circular queue of pending line-fill tags.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   alloc_en/alloc_tag - append a tag at wr_ptr
//   issue_en           - oldest waiting entry has been sent to memory
//   retire_en          - oldest issued entry has been returned
//   cmp_tag/hit        - parallel compare of cmp_tag against all allocated entries
//   iss_tag, rd_tag    - tag at the issue pointer and at the retire pointer
//   count, iss_count   - allocated entries, and how many of them are issued
// Occupancy is tracked by counters rather than pointer equality so that a
// full queue (all pointers equal) is never mistaken for an empty one.
module ifu_pend_tag_q #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 6,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 issue_en,
    input  logic                 retire_en,
    input  logic [TAG_WIDTH-1:0] cmp_tag,
    output logic                 hit,
    output logic [TAG_WIDTH-1:0] iss_tag,
    output logic [TAG_WIDTH-1:0] rd_tag,
    output logic [CNT_W-1:0]     count,
    output logic [CNT_W-1:0]     iss_count
);

    logic [TAG_WIDTH-1:0] tag_mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     iss_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     iss_cnt_r;
    logic                 hit_s;

    // Compare the incoming tag against every slot that lies inside [rd, rd+count).
    always_comb begin
        logic [PTR_W-1:0] dist_v;
        hit_s  = 1'b0;
        dist_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dist_v = PTR_W'(i) - rd_ptr_r;
            if (({1'b0, dist_v} < count_r) && (tag_mem_r[i] == cmp_tag)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Tag storage, pointer advance and occupancy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            iss_ptr_r <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            iss_cnt_r <= '0;
        end else begin
            if (alloc_en) begin
                tag_mem_r[wr_ptr_r] <= alloc_tag;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (issue_en) begin
                iss_ptr_r <= iss_ptr_r + PTR_W'(1);
            end
            if (retire_en) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({alloc_en, retire_en})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            case ({issue_en, retire_en})
                2'b10:   iss_cnt_r <= iss_cnt_r + CNT_W'(1);
                2'b01:   iss_cnt_r <= iss_cnt_r - CNT_W'(1);
                default: iss_cnt_r <= iss_cnt_r;
            endcase
        end
    end

    assign hit       = hit_s;
    assign iss_tag   = tag_mem_r[iss_ptr_r];
    assign rd_tag    = tag_mem_r[rd_ptr_r];
    assign count     = count_r;
    assign iss_count = iss_cnt_r;

endmodule

// File: rtl/ifu_mem_req_ctrl.sv
// ifu_mem_req_ctrl: miss-request controller between ifu_cache and instruction memory.
// Ports:
//   Clock - single rising-edge clock
//   Rst   - synchronous active-high reset; flushes every pending entry
//   bus   - ifu_mem_req_ctrl_if.master: cache miss request/ready, memory
//           read request (valid/ready), memory response, cache fill, sticky
//           unexpected-response error
// Tags are accepted in order with duplicate suppression, issued one per cycle
// as line-aligned reads, and retired in order as registered one-cycle fills.
module ifu_mem_req_ctrl
    import ifu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = IFU_MAX_OUTSTANDING,
    parameter int TAG_WIDTH       = IFU_TAG_WIDTH,
    parameter int LINE_WIDTH      = IFU_LINE_WIDTH,
    parameter int ADDR_WIDTH      = IFU_ADDR_WIDTH,
    parameter int OFFSET_WIDTH    = IFU_OFFSET_WIDTH
) (
    input  logic                Clock,
    input  logic                Rst,
    ifu_mem_req_ctrl_if.master  bus
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      iss_cnt_s;
    logic                  hit_s;
    logic [TAG_WIDTH-1:0]  iss_tag_s;
    logic [TAG_WIDTH-1:0]  rd_tag_s;
    logic                  ready_s;
    logic                  alloc_s;
    logic                  mem_valid_s;
    logic                  issue_s;
    logic                  retire_s;
    logic                  unexp_s;
    logic [ADDR_WIDTH-1:0] addr_s;

    logic [TAG_WIDTH-1:0]  rsp_tag_r;
    logic [LINE_WIDTH-1:0] rsp_line_r;
    logic                  rsp_valid_r;
    logic                  err_r;

    ifu_pend_tag_q #(
        .DEPTH     (MAX_OUTSTANDING),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pend_q (
        .clk       (Clock),
        .rst       (Rst),
        .alloc_en  (alloc_s),
        .alloc_tag (bus.cache_reqTagIn),
        .issue_en  (issue_s),
        .retire_en (retire_s),
        .cmp_tag   (bus.cache_reqTagIn),
        .hit       (hit_s),
        .iss_tag   (iss_tag_s),
        .rd_tag    (rd_tag_s),
        .count     (count_s),
        .iss_count (iss_cnt_s)
    );

    // Ready comes from registered occupancy only, so a retire in the same
    // cycle never opens a slot. A hit acknowledges without allocating.
    assign ready_s     = (count_s != CNT_W'(MAX_OUTSTANDING));
    assign alloc_s     = bus.cache_reqTagValidIn & ready_s & ~hit_s;

    // Something is waiting whenever not every allocated entry has been issued.
    assign mem_valid_s = (count_s != iss_cnt_s);
    assign issue_s     = mem_valid_s & bus.mem_reqReadyIn;

    // Only entries issued before this edge may retire; a response in the same
    // cycle as its own issue handshake is therefore unexpected.
    assign retire_s    = bus.mem_rspValidIn & (iss_cnt_s != CNT_W'(0));
    assign unexp_s     = bus.mem_rspValidIn & (iss_cnt_s == CNT_W'(0));

    // Line-aligned read address; forced to zero while nothing is waiting.
    always_comb begin
        addr_s = '0;
        if (mem_valid_s) begin
            addr_s = ADDR_WIDTH'({iss_tag_s, {OFFSET_WIDTH{1'b0}}});
        end else begin
            addr_s = '0;
        end
    end

    // Fill output registers and sticky unexpected-response flag.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            rsp_tag_r   <= '0;
            rsp_line_r  <= '0;
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            rsp_valid_r <= retire_s;
            if (retire_s) begin
                rsp_tag_r  <= rd_tag_s;
                rsp_line_r <= bus.mem_rspInsLineIn;
            end
            if (unexp_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.cache_reqReadyOut        = ready_s;
    assign bus.mem_reqValidOut          = mem_valid_s;
    assign bus.mem_reqAddrOut           = addr_s;
    assign bus.cache_rspTagOut          = rsp_tag_r;
    assign bus.cache_rspInsLineOut      = rsp_line_r;
    assign bus.cache_rspInsLineValidOut = rsp_valid_r;
    assign bus.err_unexpRspOut          = err_r;

endmodule

// File: tb/tb_ifu_mem_req_ctrl.sv
// tb_ifu_mem_req_ctrl: randomized, self-checking bench for ifu_mem_req_ctrl.
// A queue-based model of the pending tags predicts every output each cycle;
// directed scenarios add literal expectations for the main corner cases.
module tb_ifu_mem_req_ctrl;
    import ifu_pkg::*;

    logic Clock = 1'b0;
    logic Rst   = 1'b1;
    always #5 Clock = ~Clock;

    ifu_mem_req_ctrl_if bus ();

    ifu_mem_req_ctrl dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state: allocated tags in order; the first m_iss of them are issued
    logic [5:0]  m_q[$];
    int          m_iss = 0;
    logic [5:0]  m_tag = '0;
    logic [31:0] m_line = '0;
    bit          m_fv = 1'b0;
    bit          m_err = 1'b0;
    bit          m_ret, m_alc, m_dup;

    logic [31:0] rd_log[$];
    logic [5:0]  fill_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model update on each active edge
    always @(posedge Clock) begin
        if (Rst) begin
            m_q.delete();
            m_iss  = 0;
            m_tag  = '0;
            m_line = '0;
            m_fv   = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_ret = bus.mem_rspValidIn && (m_iss > 0);
            if (bus.mem_rspValidIn && (m_iss == 0)) m_err = 1'b1;
            m_dup = 1'b0;
            foreach (m_q[k]) if (m_q[k] == bus.cache_reqTagIn) m_dup = 1'b1;
            m_alc = bus.cache_reqTagValidIn && (m_q.size() < 4) && !m_dup;
            if ((m_q.size() > m_iss) && bus.mem_reqReadyIn) m_iss++;
            m_fv = m_ret;
            if (m_ret) begin
                m_tag  = m_q[0];
                m_line = bus.mem_rspInsLineIn;
                void'(m_q.pop_front());
                m_iss--;
            end
            if (m_alc) m_q.push_back(bus.cache_reqTagIn);
        end
    end

    // log of issued reads and delivered fills, observed on the DUT
    always @(posedge Clock) begin
        if (chk_en && !Rst) begin
            if (bus.mem_reqValidOut && bus.mem_reqReadyIn) rd_log.push_back(bus.mem_reqAddrOut);
            if (bus.cache_rspInsLineValidOut) fill_log.push_back(bus.cache_rspTagOut);
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge Clock) begin
        logic        ev;
        logic [31:0] ea;
        if (chk_en) begin
            ev = (m_q.size() > m_iss);
            ea = 32'h0;
            if (ev) ea = {21'h0, m_q[m_iss], 5'h0};
            chk("ready", {31'h0, bus.cache_reqReadyOut}, {31'h0, (m_q.size() != 4)});
            chk("mem_valid", {31'h0, bus.mem_reqValidOut}, {31'h0, ev});
            chk("mem_addr", bus.mem_reqAddrOut, ea);
            chk("fill_valid", {31'h0, bus.cache_rspInsLineValidOut}, {31'h0, m_fv});
            chk("fill_tag", {26'h0, bus.cache_rspTagOut}, {26'h0, m_tag});
            chk("fill_line", bus.cache_rspInsLineOut, m_line);
            chk("err", {31'h0, bus.err_unexpRspOut}, {31'h0, m_err});
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.cache_reqTagIn      = '0;
        bus.cache_reqTagValidIn = 1'b0;
        bus.mem_reqReadyIn      = 1'b0;
        bus.mem_rspInsLineIn    = '0;
        bus.mem_rspValidIn      = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, {31'h0, bus.cache_reqReadyOut}, 32'h1);
        chk({pfx, "_valid"}, {31'h0, bus.mem_reqValidOut}, 32'h0);
        chk({pfx, "_addr"}, bus.mem_reqAddrOut, 32'h0);
        chk({pfx, "_tag"}, {26'h0, bus.cache_rspTagOut}, 32'h0);
        chk({pfx, "_line"}, bus.cache_rspInsLineOut, 32'h0);
        chk({pfx, "_fv"}, {31'h0, bus.cache_rspInsLineValidOut}, 32'h0);
        chk({pfx, "_err"}, {31'h0, bus.err_unexpRspOut}, 32'h0);
    endtask

    // answer every issued read until the model holds nothing
    task automatic drain(input int budget);
        int k;
        k = 0;
        bus.cache_reqTagValidIn = 1'b0;
        while ((m_q.size() != 0) && (k < budget)) begin
            bus.mem_reqReadyIn   = 1'b1;
            bus.mem_rspValidIn   = (m_iss > 0);
            bus.mem_rspInsLineIn = $urandom;
            tick();
            k++;
        end
        bus.mem_rspValidIn = 1'b0;
        if (k == budget) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", m_q.size());
        end
    endtask

    // present a tag with random memory behaviour until it is accepted
    task automatic send_random(input logic [5:0] tag, input int budget);
        bit acc;
        int k;
        k = 0;
        acc = 1'b0;
        bus.cache_reqTagIn      = tag;
        bus.cache_reqTagValidIn = 1'b1;
        while (!acc && (k < budget)) begin
            bus.mem_reqReadyIn   = 1'($urandom_range(0, 1));
            bus.mem_rspValidIn   = (m_iss > 0) && ($urandom_range(0, 2) != 0);
            bus.mem_rspInsLineIn = $urandom;
            @(negedge Clock);
            acc = bus.cache_reqReadyOut;
            @(posedge Clock);
            #1;
            k++;
        end
        bus.cache_reqTagValidIn = 1'b0;
        bus.mem_rspValidIn      = 1'b0;
        if (!acc) begin
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept of tag %0h", tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0;
        idle();
        Rst = 1'b1;
        repeat (3) tick();
        Rst = 1'b0;
        chk_en = 1'b1;
        chk_reset_vals("rst");

        // single miss
        bus.cache_reqTagIn = 6'h01; bus.cache_reqTagValidIn = 1'b1; bus.mem_reqReadyIn = 1'b1;
        tick();
        bus.cache_reqTagValidIn = 1'b0;
        chk("miss_valid", {31'h0, bus.mem_reqValidOut}, 32'h1);
        chk("miss_addr", bus.mem_reqAddrOut, 32'h20);
        tick();
        tick();
        bus.mem_rspValidIn = 1'b1; bus.mem_rspInsLineIn = 32'hDEADBEEF;
        tick();
        bus.mem_rspValidIn = 1'b0;
        chk("miss_fv", {31'h0, bus.cache_rspInsLineValidOut}, 32'h1);
        chk("miss_tag", {26'h0, bus.cache_rspTagOut}, 32'h01);
        chk("miss_line", bus.cache_rspInsLineOut, 32'hDEADBEEF);
        tick();
        chk("miss_pulse", {31'h0, bus.cache_rspInsLineValidOut}, 32'h0);

        // dedup: same tag two cycles in a row
        r0 = rd_log.size(); f0 = fill_log.size();
        bus.cache_reqTagIn = 6'h02; bus.cache_reqTagValidIn = 1'b1;
        tick();
        tick();
        bus.cache_reqTagValidIn = 1'b0;
        drain(50);
        tick(); tick();
        chk("dedup_reads", rd_log.size() - r0, 32'd1);
        if (rd_log.size() > r0) chk("dedup_addr", rd_log[r0], 32'h40);
        chk("dedup_fills", fill_log.size() - f0, 32'd1);
        if (fill_log.size() > f0) chk("dedup_ftag", {26'h0, fill_log[f0]}, 32'h02);

        // full queue and backpressure
        r0 = rd_log.size();
        bus.mem_reqReadyIn = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            bus.cache_reqTagIn = 6'(t); bus.cache_reqTagValidIn = 1'b1;
            tick();
        end
        chk("full_ready", {31'h0, bus.cache_reqReadyOut}, 32'h0);
        bus.cache_reqTagIn = 6'h05; bus.mem_reqReadyIn = 1'b1;
        tick(); tick();
        chk("full_hold", {31'h0, bus.cache_reqReadyOut}, 32'h0);
        bus.mem_rspValidIn = 1'b1; bus.mem_rspInsLineIn = 32'h1234_5678;
        tick();
        bus.mem_rspValidIn = 1'b0;
        chk("full_open", {31'h0, bus.cache_reqReadyOut}, 32'h1);
        tick();
        bus.cache_reqTagValidIn = 1'b0;
        drain(100);
        tick(); tick();
        chk("full_nreads", rd_log.size() - r0, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (rd_log.size() > r0 + i) chk("full_order", rd_log[r0 + i], 32'(32 * (i + 1)));
        end

        // wrap and ordering with random ready and response gaps
        f0 = fill_log.size();
        for (int i = 0; i < 10; i++) send_random(6'(8'h10 + i), 60);
        drain(200);
        tick(); tick();
        chk("wrap_nfills", fill_log.size() - f0, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (fill_log.size() > f0 + i) chk("wrap_order", {26'h0, fill_log[f0 + i]}, 32'(8'h10 + i));
        end

        // random mix with frequent duplicates
        for (int c = 0; c < 300; c++) begin
            bus.cache_reqTagValidIn = 1'($urandom_range(0, 1));
            bus.cache_reqTagIn      = 6'($urandom_range(0, 7));
            bus.mem_reqReadyIn      = 1'($urandom_range(0, 1));
            bus.mem_rspValidIn      = (m_iss > 0) && ($urandom_range(0, 1) != 0);
            bus.mem_rspInsLineIn    = $urandom;
            tick();
        end
        drain(200);
        tick();

        // unexpected response with an empty queue
        bus.mem_rspValidIn = 1'b1; bus.mem_rspInsLineIn = 32'hBAD0BAD0;
        tick();
        bus.mem_rspValidIn = 1'b0;
        chk("unexp_err", {31'h0, bus.err_unexpRspOut}, 32'h1);
        chk("unexp_nofill", {31'h0, bus.cache_rspInsLineValidOut}, 32'h0);
        repeat (3) tick();
        chk("unexp_sticky", {31'h0, bus.err_unexpRspOut}, 32'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("unexp_clear", {31'h0, bus.err_unexpRspOut}, 32'h0);

        // reset with entries pending, then normal service
        bus.mem_reqReadyIn = 1'b0;
        for (int t = 0; t < 3; t++) begin
            bus.cache_reqTagIn = 6'(8'h31 + t); bus.cache_reqTagValidIn = 1'b1;
            tick();
        end
        bus.cache_reqTagValidIn = 1'b0;
        chk("pend_valid", {31'h0, bus.mem_reqValidOut}, 32'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk_reset_vals("midrst");
        f0 = fill_log.size();
        bus.cache_reqTagIn = 6'h07; bus.cache_reqTagValidIn = 1'b1; bus.mem_reqReadyIn = 1'b1;
        tick();
        bus.cache_reqTagValidIn = 1'b0;
        chk("post_addr", bus.mem_reqAddrOut, 32'hE0);
        drain(50);
        tick(); tick();
        chk("post_nfills", fill_log.size() - f0, 32'd1);
        if (fill_log.size() > f0) chk("post_tag", {26'h0, fill_log[f0]}, 32'h07);

        idle();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
